uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Oversampling UART receiver; the receive side of the UART interface.
- Deserialises one frame per transfer, LSB first: start bit, DATA_WIDTH data bits, optional parity bit, one stop bit.
- Each bit lasts Prescale cycles of CLK. Bits are recovered by 3-sample majority vote around mid-bit.
- A frame that passes all checks is presented on P_DATA with a one-cycle Data_Valid pulse.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame and width of P_DATA.

Ports:
- CLK  input  1  oversampling clock (Prescale cycles per bit).
- RST  input  1  reset; asynchronous, active-low.
- RX_IN  input  1  serial line; idle high.
- Prescale  input  6  clocks per bit. Supported values: 4, 8, 16, 32. Change only while idle.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Data_Valid  output  1  one-cycle pulse when a good frame completes.
- P_DATA  output  DATA_WIDTH  last good frame's data.

Behaviour:
- Reset (RST=0, asynchronous):
  - Data_Valid=0, P_DATA=0, FSM in IDLE, all counters and sample registers cleared.
- Counters:
  - edge_cnt (6b) counts 0..Prescale-1 within a bit, then wraps to 0.
  - bit_cnt (4b) counts bits within the frame; it advances when edge_cnt wraps.
- Sampling:
  - RX_IN is registered at edge_cnt = Prescale/2-1 and Prescale/2.
  - At edge_cnt = Prescale/2+1, sampled_bit = majority(the two registered samples, live RX_IN). All bit decisions happen at that cycle.
  - For Prescale=4 the sample points are 1, 2, 3.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on the cycle RX_IN=0 is seen, go to START with edge_cnt=0 counting from that cycle. Otherwise stay.
  - START: at the decision point, if sampled_bit=1 (glitch), return to IDLE immediately with no output and counters cleared. Otherwise, at edge_cnt=Prescale-1, go to DATA.
  - DATA: at each decision point, shift sampled_bit into the shift register, LSB first. After DATA_WIDTH bits, go to PARITY if PAR_EN=1, else STOP.
  - PARITY: at the decision point compare sampled_bit against the expected parity and latch par_err.
    - Expected parity, even: XOR of the data bits.
    - Expected parity, odd: inverted XOR of the data bits.
    - Go to STOP at the end of the bit.
  - STOP: at the decision point latch stp_err = ~sampled_bit.
- End of stop bit (edge_cnt=Prescale-1):
  - If par_err=0 and stp_err=0: register P_DATA from the shift register and drive Data_Valid=1 for exactly one cycle.
  - Otherwise Data_Valid stays 0 and P_DATA is unchanged.
  - Next state is START (edge_cnt=0) if RX_IN=0 in that cycle, so back-to-back frames are received with no idle gap. Otherwise IDLE.
- Error flags clear on entry to START.
- PAR_EN and PAR_TYP are sampled when the FSM leaves the last data bit. A frame with a parity or stop error produces no output. The receiver resynchronises on the next falling edge of RX_IN.
- Mid-frame reset aborts the frame immediately. No Data_Valid is produced for the aborted frame.
- Prescale values outside {4, 8, 16, 32}, or changes to Prescale mid-frame, are unsupported and produce unspecified data. The FSM must still always return to IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-type constants EVEN_PARITY=0 and ODD_PARITY=1.
- One sub-module, uart_rx_sampler: edge counter, 3-sample majority vote, sample_done strobe.
- FSM, deserialiser and the parity/stop checks stay in uart_rx.

Test Plan:
- Prescale=16, PAR_EN=0, data 0xF0, stop=1 -> Data_Valid pulses once at end of stop bit; P_DATA=0xF0.
- Prescale=16, PAR_EN=1, three frames, each -> Data_Valid pulse with P_DATA equal to the frame data:
  - 0xF0, odd parity, parity bit 1;
  - 0xF8, even parity, parity bit 1;
  - 0xF0, even parity, parity bit 0.
- Back-to-back, no idle: 0xAA (odd, parity 1) then 0x55 (even, parity 0) -> two Data_Valid pulses, P_DATA=0xAA then 0x55.
- Error frames, both 0xAA odd:
  - parity bit 0 -> no Data_Valid, P_DATA holds its previous value;
  - parity 1 with stop bit 0 -> no Data_Valid.
  - A following good frame is then received correctly.
- Start glitch: RX_IN low for 4 cycles at Prescale=16 -> FSM returns to IDLE, no Data_Valid.
- Prescale sweep, no parity:
  - 32 with 0xF0 -> P_DATA=0xF0;
  - 8 with 0x0F -> P_DATA=0x0F;
  - 4 with 0xAA -> P_DATA=0xAA.
  - Each frame gives exactly one Data_Valid pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Receiver frame states, in frame order.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Values of PAR_TYP.
    localparam logic EVEN_PARITY = 1'b0;
    localparam logic ODD_PARITY  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-timing for the UART receiver.
// Counts clocks within a bit and takes a 3-sample majority vote around mid-bit.
// Asserts sample_done on the cycle the vote is valid.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    input  logic       run,          // count this cycle (a frame is in progress)
    input  logic       clear,        // abandon the current bit, restart from zero
    output logic       edge_last,    // last clock of the current bit
    output logic       sample_done,  // sampled_bit is valid this cycle
    output logic       sampled_bit
);

    logic [5:0] edge_cnt;
    logic [5:0] half;
    logic       smp_a;
    logic       smp_b;

    assign half        = {1'b0, prescale[5:1]};
    assign edge_last   = (edge_cnt == prescale - 6'd1);
    assign sample_done = run && (edge_cnt == half + 6'd1);
    // The third vote is the live line, so the decision lands one clock after the second sample.
    assign sampled_bit = (smp_a & smp_b) | (smp_a & rx_in) | (smp_b & rx_in);

    // Edge counter, plus capture of the two registered samples around mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            smp_a    <= 1'b0;
            smp_b    <= 1'b0;
        end else if (clear || !run) begin
            edge_cnt <= '0;
            smp_a    <= 1'b0;
            smp_b    <= 1'b0;
        end else begin
            // Plain 6-bit overflow also returns to zero, so an out-of-range prescale cannot stall.
            edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
            if (edge_cnt == half - 6'd1) smp_a <= rx_in;
            if (edge_cnt == half)        smp_b <= rx_in;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver.
// Frame format: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
// Good frames are presented on P_DATA with a one-cycle Data_Valid pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  Data_Valid,
    output logic [DATA_WIDTH-1:0] P_DATA
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

    rx_state_e             state;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_typ_q;
    logic                  par_err;
    logic                  stp_err;

    logic run;
    logic glitch;
    logic edge_last;
    logic sample_done;
    logic sampled_bit;
    logic stop_bad;

    // The cycle that first sees the line low in IDLE counts as clock 0 of the start bit.
    assign run    = (state != IDLE) || !RX_IN;
    assign glitch = (state == START) && sample_done && sampled_bit;
    // At the smallest prescale the stop decision and the end of the bit share a cycle,
    // so take the live vote when it is there.
    assign stop_bad = sample_done ? ~sampled_bit : stp_err;

    uart_rx_sampler u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .rx_in       (RX_IN),
        .prescale    (Prescale),
        .run         (run),
        .clear       (glitch),
        .edge_last   (edge_last),
        .sample_done (sample_done),
        .sampled_bit (sampled_bit)
    );

    // Frame FSM with deserialiser, parity/stop checks and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_typ_q  <= EVEN_PARITY;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    if (!RX_IN) begin
                        state   <= START;
                        par_err <= 1'b0;
                        stp_err <= 1'b0;
                    end
                end
                START: begin
                    if (glitch) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end else if (edge_last) begin
                        state   <= DATA;
                        bit_cnt <= 4'd1;
                    end
                end
                DATA: begin
                    if (sample_done) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                    if (edge_last) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_DATA) begin
                            par_typ_q <= PAR_TYP;
                            state     <= PAR_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    // Even: bit equals XOR of data; odd: its inverse.
                    if (sample_done) par_err <= sampled_bit ^ (^shreg) ^ par_typ_q;
                    if (edge_last) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (sample_done) stp_err <= ~sampled_bit;
                    if (edge_last) begin
                        if (!par_err && !stop_bad) begin
                            P_DATA     <= shreg;
                            Data_Valid <= 1'b1;
                        end
                        bit_cnt <= '0;
                        if (!RX_IN) begin
                            state   <= START;
                            par_err <= 1'b0;
                            stp_err <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Runs directed frames from the test plan, then random frames scored by a frame-level model.
module tb_uart_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         rx_in = 1'b1;
    logic [5:0]   prescale = 6'd16;
    logic         par_en = 1'b0;
    logic         par_typ = 1'b0;
    logic         data_valid;
    logic [W-1:0] p_data;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_pdata = '0;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .CLK        (clk),
        .RST        (rst),
        .RX_IN      (rx_in),
        .Prescale   (prescale),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Data_Valid (data_valid),
        .P_DATA     (p_data)
    );

    always #5 clk = ~clk;

    // Record every cycle Data_Valid is high; a stretched pulse shows up as an extra entry.
    always @(negedge clk) if (data_valid) got_q.push_back(p_data);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Parity bit that makes the frame valid: even -> total ones even; odd -> inverted.
    function automatic bit good_parity(input logic [W-1:0] d, input bit pt);
        return bit'(($countones(d) % 2) == 1) ^ pt;
    endfunction

    function automatic bit frame_good(input logic [W-1:0] d, input bit pe, input bit pt,
                                      input bit pb, input bit sb);
        return sb && (!pe || pb == good_parity(d, pt));
    endfunction

    task automatic send_bit(input bit b);
        rx_in = b;
        repeat (prescale) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt,
                              input bit pb, input bit sb);
        par_en  = pe;
        par_typ = pt;
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        if (pe) send_bit(pb);
        send_bit(sb);
    endtask

    // Idle the line for two bit times, then score the captured pulses against the expected frames.
    task automatic settle_and_check(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                                    input int n_exp);
        rx_in = 1'b1;
        repeat (2 * prescale) @(negedge clk);
        chk({tag, "_pulses"}, got_q.size(), n_exp);
        if (n_exp >= 1) begin
            exp_pdata = e0;
            if (got_q.size() >= 1) chk({tag, "_data0"}, got_q[0], e0);
        end
        if (n_exp >= 2) begin
            exp_pdata = e1;
            if (got_q.size() >= 2) chk({tag, "_data1"}, got_q[1], e1);
        end
        chk({tag, "_pdata"}, p_data, exp_pdata);
        got_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [W-1:0] d, input bit pe, input bit pt,
                             input bit pb, input bit sb);
        send_frame(d, pe, pt, pb, sb);
        settle_and_check(tag, d, '0, frame_good(d, pe, pt, pb, sb) ? 1 : 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", data_valid, 1'b0);
        chk("rst_pdata", p_data, '0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Directed frames at Prescale=16
        prescale = 6'd16;
        run_frame("np_f0", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frame("odd_f0", 8'hF0, 1'b1, 1'b1, 1'b1, 1'b1);
        run_frame("even_f8", 8'hF8, 1'b1, 1'b0, 1'b1, 1'b1);
        run_frame("even_f0", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back frames with no idle gap
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        settle_and_check("b2b", 8'hAA, 8'h55, 2);

        // Error frames, then recovery
        run_frame("par_err", 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1);
        run_frame("stp_err", 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
        run_frame("recover", 8'h3C, 1'b1, 1'b1, good_parity(8'h3C, 1'b1), 1'b1);

        // Start glitch: 4 low cycles at Prescale=16
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        settle_and_check("glitch", '0, '0, 0);
        run_frame("post_glitch", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

        // Prescale sweep, no parity
        prescale = 6'd32; run_frame("ps32", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        prescale = 6'd8;  run_frame("ps8", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        prescale = 6'd4;  run_frame("ps4", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1);

        // Mid-frame reset aborts the frame and clears P_DATA
        prescale = 6'd16;
        par_en   = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b0;
        #3;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_pdata = '0;
        settle_and_check("mid_rst", '0, '0, 0);
        run_frame("post_rst", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random frames across prescales, parity modes and injected errors
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] d;
            bit pe, pt, pb, sb;
            case ($urandom_range(0, 3))
                0:       prescale = 6'd4;
                1:       prescale = 6'd8;
                2:       prescale = 6'd16;
                default: prescale = 6'd32;
            endcase
            d  = W'($urandom);
            pe = bit'($urandom_range(0, 1));
            pt = bit'($urandom_range(0, 1));
            pb = good_parity(d, pt) ^ ($urandom_range(0, 4) == 0);
            sb = ($urandom_range(0, 5) != 0);
            run_frame($sformatf("rnd%0d", n), d, pe, pt, pb, sb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
